// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor: registered bitwise 2-of-3 voter for a triplicated datapath.
// It also counts disagreeing samples with a saturating counter and runs a
// per-replica OK/SUSPECT/FAILED tracker. A level clear request is acknowledged
// with a single-cycle pulse.
module tmr_vote_monitor #(
  parameter int WIDTH   = 13,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rep_a,
  input  logic [WIDTH-1:0] rep_b,
  input  logic [WIDTH-1:0] rep_c,
  input  logic             clr_req,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_voted,
  output logic             err_pulse,
  output logic             fault_a,
  output logic             fault_b,
  output logic             fault_c,
  output logic [CNT_W-1:0] err_count,
  output logic             clr_ack
);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAILED} rep_state_t;

  localparam logic [3:0]       PERSIST_L = 4'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [WIDTH-1:0] vote_comb;
  logic             disagree;
  logic [2:0]       mism;
  logic             accept;
  logic [2:0]       fault_vec;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_voted_q, y_voted_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             clr_ack_q, clr_ack_d;
  // armed_q: clr_req has been seen low since the last accepted clear
  logic             armed_q, armed_d;

  // Unregistered vote and mismatch detection for the current sample
  always_comb begin
    vote_comb = (rep_a & rep_b) | (rep_a & rep_c) | (rep_b & rep_c);
    disagree  = in_valid && !((rep_a == rep_b) && (rep_b == rep_c));
    mism[0]   = in_valid && (rep_a != vote_comb);
    mism[1]   = in_valid && (rep_b != vote_comb);
    mism[2]   = in_valid && (rep_c != vote_comb);
    accept    = clr_req && !clr_ack_q && armed_q;
  end

  // Next-state for the voted output, error pulse, counter and clear handshake
  always_comb begin
    out_valid_d = in_valid;
    y_voted_d   = y_voted_q;
    err_pulse_d = disagree;
    err_count_d = err_count_q;
    clr_ack_d   = accept;
    armed_d     = armed_q;
    if (in_valid) begin
      y_voted_d = vote_comb;
    end
    // Clear takes priority over any count effect of the same-cycle sample
    if (accept) begin
      err_count_d = '0;
    end else if (disagree && !(&err_count_q)) begin
      err_count_d = err_count_q + CNT_ONE;
    end
    if (accept) begin
      armed_d = 1'b0;
    end else if (!clr_req) begin
      armed_d = 1'b1;
    end
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_voted_q   <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      clr_ack_q   <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      y_voted_q   <= y_voted_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      clr_ack_q   <= clr_ack_d;
      armed_q     <= armed_d;
    end
  end

  // One persistence tracker per replica (0 = A, 1 = B, 2 = C)
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rep
      rep_state_t state_q, state_d;
      logic [3:0] pc_q, pc_d;
      logic [3:0] pc_inc;

      // Tracker next-state: escalate on mismatches, relax on a clean sample
      always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc_inc  = pc_q + 4'd1;
        if (accept) begin
          state_d = ST_OK;
          pc_d    = 4'd0;
        end else begin
          case (state_q)
            ST_OK: begin
              if (mism[gi]) begin
                pc_d    = 4'd1;
                state_d = (PERSIST_L == 4'd1) ? ST_FAILED : ST_SUSPECT;
              end
            end
            ST_SUSPECT: begin
              if (mism[gi]) begin
                pc_d = pc_inc;
                if (pc_inc >= PERSIST_L) begin
                  state_d = ST_FAILED;
                end
              end else if (in_valid) begin
                state_d = ST_OK;
                pc_d    = 4'd0;
              end
            end
            ST_FAILED: begin
              state_d = ST_FAILED;
            end
            default: begin
              state_d = ST_OK;
              pc_d    = 4'd0;
            end
          endcase
        end
      end

      // Tracker state register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_OK;
          pc_q    <= 4'd0;
        end else begin
          state_q <= state_d;
          pc_q    <= pc_d;
        end
      end

      assign fault_vec[gi] = (state_q == ST_FAILED);
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign y_voted   = y_voted_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign clr_ack   = clr_ack_q;
  assign fault_a   = fault_vec[0];
  assign fault_b   = fault_vec[1];
  assign fault_c   = fault_vec[2];

endmodule
